// File: rtl/regfile_pkg.sv
// Shared widths and types for the general-purpose register file.
// X31 is the hardwired zero register.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_row.sv
// One storage row: flops with async active-high clear and load enable.
// Clear has priority over load.
module reg_row
  import regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two combinational reads, one clocked write.
// Define REGFILE_BYPASS_EN to forward the write port onto the reads.
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rows [NUM_REGS];

  // The top row has no flops: it is the constant-zero register.
  assign rows[NUM_REGS-1] = '0;

  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_row
    logic ld;

    assign ld = wr_en && (wr_addr == ADDR_W'(i));

    reg_row #(
      .W (DATA_W)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (ld),
      .d   (wr_data),
      .q   (rows[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  logic fwd1;
  logic fwd2;

  assign fwd_ok = !rst && wr_en && (wr_addr != ZR);
  assign fwd1   = fwd_ok && (wr_addr == rd_addr1);
  assign fwd2   = fwd_ok && (wr_addr == rd_addr2);

  assign rd_data1 = fwd1 ? wr_data : rows[rd_addr1];
  assign rd_data2 = fwd2 ? wr_data : rows[rd_addr2];
`else
  assign rd_data1 = rows[rd_addr1];
  assign rd_data2 = rows[rd_addr2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference model plus
// scoreboard queue of expected read-port values.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] model [32];
  string       tagq [$];
  logic [31:0] expq [$];

  int errs;
  int checks;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (rst) return 32'h0;
    if (a == 5'd31) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return model[a];
  endfunction

  // Drive read addresses, queue expectations, sample 1 unit later.
  task automatic rd(string tag, logic [4:0] a1, logic [4:0] a2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    tagq.push_back($sformatf("%s_p1[%0d]", tag, a1));
    expq.push_back(exp_rd(a1));
    tagq.push_back($sformatf("%s_p2[%0d]", tag, a2));
    expq.push_back(exp_rd(a2));
    #1;
    check(tagq.pop_front(), rd_data1, expq.pop_front());
    check(tagq.pop_front(), rd_data2, expq.pop_front());
  endtask

  task automatic drive(logic en, logic [4:0] a, logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst && wr_en && wr_addr != 5'd31) model[wr_addr] = wr_data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    drive(1'b1, a, d);
    step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    rst      = 1'b1;
    rd_addr1 = '0;
    rd_addr2 = '0;
    drive(1'b0, '0, '0);
    clear_model();

    // Reset state
    @(negedge clk);
    rd("rst", 5'd0, 5'd30);
    @(negedge clk);
    rst = 1'b0;
    rd("post_rst", 5'd7, 5'd31);

    // Fill X0..X30, then assert reset between edges
    for (int i = 0; i < 31; i++) wr(5'(i), 32'hA5A5_0000 + i);
    rd("fill", 5'd0, 5'd30);
    rd("fill", 5'd15, 5'd31);
    #2;
    rst = 1'b1;
    clear_model();
    rd("async_clr", 5'd0, 5'd30);
    rd("async_clr", 5'd15, 5'd1);
    step();
    rd("rst_hold", 5'd2, 5'd29);
    rst = 1'b0;

    // Basic write/read
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd17, 32'h1234_5678);
    rd("basic", 5'd5, 5'd17);
    rd("basic", 5'd6, 5'd5);

    // Zero register ignores writes
    wr(5'd31, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      rd("xzr", 5'd31, 5'd17);
      step();
    end
    rd("xzr_other", 5'd5, 5'd30);

    // Same-cycle write/read of X9
    wr(5'd9, 32'h0000_0001);
    drive(1'b1, 5'd9, 32'h0000_0002);
    rd("x9_pre", 5'd9, 5'd5);
    step();
    rd("x9_post", 5'd9, 5'd31);

    // Write strobe low
    drive(1'b0, 5'd3, 32'hCAFE_F00D);
    step();
    rd("wr_en_low", 5'd3, 5'd9);

    // Reset wins over a write in the same cycle
    rst = 1'b1;
    drive(1'b1, 5'd12, 32'h0BAD_0BAD);
    clear_model();
    rd("rst_vs_wr", 5'd12, 5'd9);
    step();
    rst = 1'b0;
    rd("rst_vs_wr_after", 5'd12, 5'd5);

    // Random traffic, reads both before and after each edge
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom);
      rd("rnd_pre", wr_addr, 5'($urandom_range(0, 31)));
      step();
      rd("rnd_post", 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
